// File: rtl/eth_txcrc_pkg.sv
// eth_txcrc_pkg
//   Shared definitions for the Ethernet transmit CRC sequencer.
//   - state_t      : sequencer state encoding (IDLE=0 .. GAP=5)
//   - FCS_NIBBLES  : FCS length in nibbles
//   - CRC_RESIDUE  : CRC register value left after a frame plus its own FCS
//   - fcs_nibble() : inverts and bit-reverses the top register nibble
//                    into MII transmit order
package eth_txcrc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_PAD   = 3'd2,
        ST_FCS   = 3'd3,
        ST_ABORT = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int unsigned FCS_NIBBLES = 8;
    localparam logic [31:0] CRC_RESIDUE = 32'hc704dd7b;

    // msn is Crc[31:28]; Crc[31] is the first bit on the wire, so it lands
    // in TxData[0], inverted.
    function automatic logic [3:0] fcs_nibble(input logic [3:0] msn);
        return {~msn[0], ~msn[1], ~msn[2], ~msn[3]};
    endfunction

endpackage

// File: rtl/eth_txcrc_fcs_shift.sv
// eth_txcrc_fcs_shift
//   Captures the CRC engine register once at the start of the FCS and
//   shifts it out one nibble per clock in MII transmit order.
// Ports:
//   Clk, Resetn : clock, asynchronous active-low reset
//   Load        : first FCS nibble; Nibble comes straight from Crc and the
//                 remaining 28 bits are stored
//   Shift       : later FCS nibbles; Nibble comes from the hold register
//                 and the register shifts left by 4
//   Crc         : CRC engine register value
//   Nibble      : inverted, bit-reversed FCS nibble for TxData
module eth_txcrc_fcs_shift
    import eth_txcrc_pkg::*;
(
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        Load,
    input  logic        Shift,
    input  logic [31:0] Crc,
    output logic [3:0]  Nibble
);

    logic [31:0] hold;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            hold <= '0;
        end else if (Load) begin
            hold <= {Crc[27:0], 4'h0};
        end else if (Shift) begin
            hold <= {hold[27:0], 4'h0};
        end
    end

    assign Nibble = fcs_nibble(Load ? Crc[31:28] : hold[31:28]);

endmodule

// File: rtl/eth_txcrc_seq.sv
// eth_txcrc_seq
//   Transmit sequencer for the shared nibble-wide Ethernet CRC-32 engine.
//   Forwards a gapless payload nibble stream to the MII path, drives the
//   engine Data/Enable/Initialize, appends the 8-nibble FCS, flags underrun
//   and enforces the inter-frame gap.
//   Build option: define ETH_TXCRC_PAD_EN to zero-pad frames shorter than
//   MIN_NIBBLES (padding is covered by the CRC).
// Ports:
//   Clk, Resetn      : clock, asynchronous active-low reset
//   InData/InValid   : payload nibble (low nibble of each byte first)
//   InStart/InLast   : frame delimiters, qualified by InValid
//   InReady          : nibbles accepted (combinational from state)
//   CrcData/CrcEnable/CrcInit : CRC engine controls (combinational)
//   Crc              : CRC engine register value
//   TxData/TxEn/TxErr: registered MII transmit outputs
//   Underrun         : one-cycle pulse when a frame is aborted
//   Busy             : sequencer not idle
module eth_txcrc_seq
    import eth_txcrc_pkg::*;
#(
    parameter int unsigned IFG_NIBBLES = 24,
    parameter int unsigned MIN_NIBBLES = 120
) (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic [3:0]  InData,
    input  logic        InValid,
    input  logic        InStart,
    input  logic        InLast,
    output logic        InReady,
    output logic [3:0]  CrcData,
    output logic        CrcEnable,
    output logic        CrcInit,
    input  logic [31:0] Crc,
    output logic [3:0]  TxData,
    output logic        TxEn,
    output logic        TxErr,
    output logic        Underrun,
    output logic        Busy
);

    localparam logic [7:0] GapLast = 8'(IFG_NIBBLES - 1);
    localparam logic [2:0] FcsLast = 3'(FCS_NIBBLES - 1);

    state_t      state;
    logic [6:0]  cnt;
    logic [6:0]  cnt_sat;
    logic [2:0]  fcs_idx;
    logic [7:0]  gap_cnt;
    logic        fcs_load;
    logic        fcs_shift;
    logic [3:0]  fcs_nib;
    state_t      first_last_next;
    state_t      data_last_next;

    assign cnt_sat = (cnt == 7'h7f) ? cnt : cnt + 7'd1;

`ifdef ETH_TXCRC_PAD_EN
    localparam logic [7:0] MinCnt = 8'(MIN_NIBBLES);
    logic [7:0] cnt_inc;

    // cnt_inc is the nibble count including the nibble accepted this cycle.
    assign cnt_inc         = {1'b0, cnt} + 8'd1;
    assign first_last_next = (8'd1 < MinCnt) ? ST_PAD : ST_FCS;
    assign data_last_next  = (cnt_inc < MinCnt) ? ST_PAD : ST_FCS;
`else
    assign first_last_next = ST_FCS;
    assign data_last_next  = ST_FCS;
`endif

    assign fcs_load  = (state == ST_FCS) && (fcs_idx == 3'd0);
    assign fcs_shift = (state == ST_FCS) && (fcs_idx != 3'd0);
    assign Busy      = (state != ST_IDLE);

    eth_txcrc_fcs_shift u_fcs (
        .Clk    (Clk),
        .Resetn (Resetn),
        .Load   (fcs_load),
        .Shift  (fcs_shift),
        .Crc    (Crc),
        .Nibble (fcs_nib)
    );

    // The engine clocks every cycle: Initialize is held everywhere except
    // while payload or padding is being fed, so it starts clean next frame.
    always_comb begin
        InReady   = 1'b0;
        CrcData   = '0;
        CrcEnable = 1'b0;
        CrcInit   = 1'b1;
        case (state)
            ST_IDLE: begin
                InReady   = 1'b1;
                CrcData   = InData;
                CrcEnable = InValid & InStart;
                CrcInit   = ~(InValid & InStart);
            end
            ST_DATA: begin
                InReady   = 1'b1;
                CrcData   = InData;
                CrcEnable = InValid;
                CrcInit   = 1'b0;
            end
`ifdef ETH_TXCRC_PAD_EN
            ST_PAD: begin
                CrcEnable = 1'b1;
                CrcInit   = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            fcs_idx  <= '0;
            gap_cnt  <= '0;
            TxData   <= '0;
            TxEn     <= 1'b0;
            TxErr    <= 1'b0;
            Underrun <= 1'b0;
        end else begin
            TxErr    <= 1'b0;
            Underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    TxEn   <= 1'b0;
                    TxData <= '0;
                    if (InValid && InStart) begin
                        TxEn    <= 1'b1;
                        TxData  <= InData;
                        cnt     <= 7'd1;
                        fcs_idx <= '0;
                        state   <= InLast ? first_last_next : ST_DATA;
                    end
                end
                ST_DATA: begin
                    TxEn <= 1'b1;
                    if (InValid) begin
                        TxData <= InData;
                        cnt    <= cnt_sat;
                        if (InLast) begin
                            state <= data_last_next;
                        end
                    end else begin
                        // Starved mid-frame: keep TxEn up with a neutral
                        // nibble so the error cycle follows without a bubble.
                        TxData <= '0;
                        state  <= ST_ABORT;
                    end
                end
`ifdef ETH_TXCRC_PAD_EN
                ST_PAD: begin
                    TxEn   <= 1'b1;
                    TxData <= '0;
                    cnt    <= cnt_sat;
                    if (cnt_inc >= MinCnt) begin
                        state <= ST_FCS;
                    end
                end
`endif
                ST_FCS: begin
                    TxEn    <= 1'b1;
                    TxData  <= fcs_nib;
                    fcs_idx <= fcs_idx + 3'd1;
                    if (fcs_idx == FcsLast) begin
                        fcs_idx <= '0;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_ABORT: begin
                    TxEn     <= 1'b1;
                    TxErr    <= 1'b1;
                    TxData   <= '0;
                    Underrun <= 1'b1;
                    gap_cnt  <= '0;
                    state    <= ST_GAP;
                end
                ST_GAP: begin
                    TxEn   <= 1'b0;
                    TxData <= '0;
                    if (gap_cnt == GapLast) begin
                        gap_cnt <= '0;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    TxEn   <= 1'b0;
                    TxData <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_txcrc_seq.sv
`timescale 1ns/1ps
module tb_eth_txcrc_seq;
    import eth_txcrc_pkg::*;

    localparam int unsigned IFG  = 24;
    localparam int unsigned MINN = 120;

    typedef logic [3:0] nib_q_t[$];
    typedef struct packed {
        logic [3:0] d;
        logic       err;
        logic       und;
    } rec_t;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b1;
    logic [3:0]  InData = '0;
    logic        InValid = 1'b0;
    logic        InStart = 1'b0;
    logic        InLast = 1'b0;
    logic        InReady;
    logic [3:0]  CrcData;
    logic        CrcEnable;
    logic        CrcInit;
    logic [31:0] crc_eng = 32'hffffffff;
    logic [3:0]  TxData;
    logic        TxEn;
    logic        TxErr;
    logic        Underrun;
    logic        Busy;

    int     errors = 0;
    int     checks = 0;
    int     frames_done = 0;
    int     last_hi = 0;
    int     last_lo = 0;
    rec_t   exp_q[$];
    nib_q_t cap_q;
    nib_q_t last_cap;

    always #5 Clk = ~Clk;

    eth_txcrc_seq #(.IFG_NIBBLES(IFG), .MIN_NIBBLES(MINN)) dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .InData    (InData),
        .InValid   (InValid),
        .InStart   (InStart),
        .InLast    (InLast),
        .InReady   (InReady),
        .CrcData   (CrcData),
        .CrcEnable (CrcEnable),
        .CrcInit   (CrcInit),
        .Crc       (crc_eng),
        .TxData    (TxData),
        .TxEn      (TxEn),
        .TxErr     (TxErr),
        .Underrun  (Underrun),
        .Busy      (Busy)
    );

    // Behavioural CRC engine: serial MSB-first CRC-32, Data bit 0 first,
    // Enable=0 shifts the register by a nibble.
    function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 4; b++) begin
            fb = r[31] ^ d[b];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    always @(posedge Clk) begin
        if (CrcInit)        crc_eng <= 32'hffffffff;
        else if (CrcEnable) crc_eng <= eng_step(crc_eng, CrcData);
        else                crc_eng <= {crc_eng[27:0], 4'h0};
    end

    // Reference: reflected CRC-32 over the nibble stream in wire order.
    function automatic logic [31:0] refl_run(input nib_q_t q);
        logic [31:0] c;
        c = 32'hffffffff;
        foreach (q[i]) begin
            for (int b = 0; b < 4; b++) begin
                if (c[0] ^ q[i][b]) c = (c >> 1) ^ 32'hEDB88320;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Expected TxEn-high nibble sequence for a good frame.
    function automatic nib_q_t model_tx(input nib_q_t p);
        nib_q_t      t;
        logic [31:0] fcs;
        t = p;
`ifdef ETH_TXCRC_PAD_EN
        while (t.size() < int'(MINN)) t.push_back(4'h0);
`endif
        fcs = ~refl_run(t);
        for (int i = 0; i < 8; i++) t.push_back(fcs[4*i +: 4]);
        return t;
    endfunction

    function automatic nib_q_t rand_payload(input int unsigned len);
        nib_q_t p;
        for (int unsigned i = 0; i < len; i++) p.push_back(4'($urandom));
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        rec_t e;
        rec_t a;
        bit   prev_en;
        int   hi;
        int   lo;
        prev_en = 1'b0;
        hi = 0;
        lo = 0;
        forever begin
            @(negedge Clk);
            if (!Resetn) begin
                prev_en = 1'b0;
                hi = 0;
                lo = 0;
                cap_q.delete();
            end else if (TxEn) begin
                if (!prev_en) begin
                    last_lo = lo;
                    hi = 0;
                    cap_q.delete();
                end
                hi++;
                cap_q.push_back(TxData);
                a = '{d: TxData, err: TxErr, und: Underrun};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got d=%h err=%b und=%b with nothing expected", a.d, a.err, a.und);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL tx_nibble: got d=%h err=%b und=%b expected d=%h err=%b und=%b",
                                 a.d, a.err, a.und, e.d, e.err, e.und);
                    end
                end
                prev_en = 1'b1;
            end else begin
                checks++;
                if (TxErr || Underrun) begin
                    errors++;
                    $display("FAIL idle_flags: got err=%b und=%b expected 0 0 while TxEn low", TxErr, Underrun);
                end
                if (prev_en) begin
                    last_hi = hi;
                    last_cap = cap_q;
                    frames_done++;
                    lo = 0;
                end
                lo++;
                prev_en = 1'b0;
            end
        end
    endtask

    // Present first nibble with InValid&InStart held until accepted, then
    // stream the rest gaplessly.
    task automatic drive(input nib_q_t p, input bit mark_last, output int waited);
        waited = 0;
        InValid = 1'b1;
        InStart = 1'b1;
        InData  = p[0];
        InLast  = mark_last && (p.size() == 1);
        while (!InReady && waited < 2000) begin
            @(negedge Clk);
            waited++;
        end
        check("ready_wait", {31'd0, InReady}, 32'd1);
        for (int i = 0; i < p.size(); i++) begin
            InData  = p[i];
            InStart = (i == 0);
            InLast  = mark_last && (i == p.size() - 1);
            InValid = 1'b1;
            @(negedge Clk);
        end
        InValid = 1'b0;
        InStart = 1'b0;
        InLast  = 1'b0;
        InData  = '0;
    endtask

    task automatic send_frame(input nib_q_t p, output int waited, output int exp_n);
        nib_q_t t;
        t = model_tx(p);
        foreach (t[i]) exp_q.push_back('{d: t[i], err: 1'b0, und: 1'b0});
        exp_n = t.size();
        drive(p, 1'b1, waited);
    endtask

    task automatic abort_frame(input nib_q_t p);
        int w;
        foreach (p[i]) exp_q.push_back('{d: p[i], err: 1'b0, und: 1'b0});
        exp_q.push_back('{d: 4'h0, err: 1'b0, und: 1'b0});
        exp_q.push_back('{d: 4'h0, err: 1'b1, und: 1'b1});
        drive(p, 1'b0, w);
        @(negedge Clk);
    endtask

    task automatic wait_frames(input int target);
        int c;
        c = 0;
        while (frames_done < target && c < 3000) begin
            @(negedge Clk);
            c++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
        end
    endtask

    task automatic check_good_frame(input string tag, input int exp_n);
        check({tag, "_len"}, 32'(last_hi), 32'(exp_n));
        check({tag, "_residue"}, bitrev32(refl_run(last_cap)), CRC_RESIDUE);
    endtask

    initial begin
        int          fd;
        int          n;
        int          n2;
        int          w;
        int          zeros;
        logic [7:0]  ch;
        logic [3:0]  exp_fcs[8];
        int unsigned lens[8];
        nib_q_t      p;
        nib_q_t      p2;

        fork
            monitor();
        join_none

        // Reset state
        #2 Resetn = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_txen",     {31'd0, TxEn},     32'd0);
        check("rst_txdata",   {28'd0, TxData},   32'd0);
        check("rst_txerr",    {31'd0, TxErr},    32'd0);
        check("rst_underrun", {31'd0, Underrun}, 32'd0);
        check("rst_inready",  {31'd0, InReady},  32'd1);
        check("rst_crcinit",  {31'd0, CrcInit},  32'd1);
        check("rst_crcen",    {31'd0, CrcEnable},32'd0);
        check("rst_busy",     {31'd0, Busy},     32'd0);
        Resetn = 1'b1;
        @(negedge Clk);

        // Stray InValid without InStart in IDLE
        for (int i = 0; i < 5; i++) begin
            InValid = 1'b1;
            InStart = 1'b0;
            InData  = 4'($urandom);
            #1;
            check("stray_crcen",   {31'd0, CrcEnable}, 32'd0);
            check("stray_crcinit", {31'd0, CrcInit},   32'd1);
            @(negedge Clk);
        end
        InValid = 1'b0;
        check("stray_crc",  crc_eng, 32'hffffffff);
        check("stray_busy", {31'd0, Busy}, 32'd0);
        check("stray_txen", {31'd0, TxEn}, 32'd0);

        // "123456789"
        p.delete();
        for (int k = 0; k < 9; k++) begin
            ch = 8'h31 + 8'(k);
            p.push_back(ch[3:0]);
            p.push_back(ch[7:4]);
        end
        fd = frames_done;
        send_frame(p, w, n);
        wait_frames(fd + 1);
        check_good_frame("ascii", n);
`ifdef ETH_TXCRC_PAD_EN
        check("ascii_pad_len", 32'(last_hi), 32'd128);
        zeros = 0;
        for (int i = 18; i < 120 && i < last_cap.size(); i++) if (last_cap[i] == 4'h0) zeros++;
        check("ascii_pad_zeros", 32'(zeros), 32'd102);
`else
        check("ascii_len", 32'(last_hi), 32'd26);
        exp_fcs = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        for (int i = 0; i < 8; i++)
            if (last_cap.size() >= 8)
                check("ascii_fcs_nibble", {28'd0, last_cap[last_cap.size()-8+i]}, {28'd0, exp_fcs[i]});
`endif

        // Boundary and random lengths, random data
        lens = '{1, 2, 119, 120, 127, 140, $urandom_range(3, 40), $urandom_range(41, 118)};
        foreach (lens[j]) begin
            p = rand_payload(lens[j]);
            fd = frames_done;
            send_frame(p, w, n);
            wait_frames(fd + 1);
            check_good_frame("rand", n);
        end

        // Underrun after 10 nibbles, next frame held ready through the gap
        fd = frames_done;
        abort_frame(rand_payload(10));
        wait_frames(fd + 1);
        check("abort_len", 32'(last_hi), 32'd12);
        p = rand_payload($urandom_range(5, 30));
        send_frame(p, w, n);
        wait_frames(fd + 2);
        check("abort_gap", 32'(last_lo), 32'(IFG));
        check_good_frame("post_abort", n);

        // Back-to-back with InValid&InStart held
        fd = frames_done;
        p  = rand_payload(125);
        p2 = rand_payload(125);
        send_frame(p, w, n);
        send_frame(p2, w, n2);
        check("b2b_ready_low", 32'(w), 32'(FCS_NIBBLES + IFG));
        wait_frames(fd + 2);
        check("b2b_gap", 32'(last_lo), 32'(IFG));
        check_good_frame("b2b", n2);

        // Reset asserted during the FCS
        p = rand_payload(125);
        send_frame(p, w, n);
        repeat (4) @(negedge Clk);
        #1;
        check("pre_rst_txen", {31'd0, TxEn}, 32'd1);
        Resetn = 1'b0;
        #1;
        check("async_rst_txen",   {31'd0, TxEn},   32'd0);
        check("async_rst_txdata", {28'd0, TxData}, 32'd0);
        check("async_rst_txerr",  {31'd0, TxErr},  32'd0);
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        #1;
        check("rel_crcinit", {31'd0, CrcInit}, 32'd1);
        check("rel_inready", {31'd0, InReady}, 32'd1);
        @(negedge Clk);
        fd = frames_done;
        p = rand_payload($urandom_range(20, 60));
        send_frame(p, w, n);
        wait_frames(fd + 1);
        check_good_frame("post_rst", n);

        repeat (30) @(negedge Clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
